mod_n_pwm: RTL
==============

MOD_N_PWM -- requirements
Module: mod_n_pwm

Interface
REQ-001 SHALL have parameter N, default 17, meaning the modulus of the upstream mod-N counter (N >= 2).
REQ-002 SHALL have derived localparam CW = $clog2(N), meaning the count width.
REQ-003 SHALL have derived localparam DW = $clog2(N+1), meaning the duty width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock shared with the upstream counter.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cnt, input, CW bits: count from the upstream mod-N counter.
REQ-008 SHALL have port duty_data, input, DW bits: requested high time, in counts per period.
REQ-009 SHALL have port duty_valid, input, 1 bit: duty_data is valid.
REQ-010 SHALL have port duty_ready, output, 1 bit: block can accept a duty value.
REQ-011 SHALL have port pwm, output, 1 bit: registered PWM waveform.
REQ-012 SHALL have port wrap, output, 1 bit: one-cycle pulse marking period end.
REQ-013 SHALL have port upd_done, output, 1 bit: one-cycle pulse when the new duty takes effect.
REQ-014 SHALL have port err, output, 1 bit: sticky flag, set when an illegal cnt is seen.

Function
REQ-015 SHALL hold three registers:
- active_duty (DW bits), used for comparison;
- shadow_duty (DW bits);
- state, with values IDLE and PEND.
REQ-016 SHALL drive duty_ready = 1 in IDLE and 0 in PEND; duty_ready is combinational from state only.
REQ-017 SHALL treat duty_valid && duty_ready at a rising edge as an accept, with two effects:
- shadow_duty <= min(duty_data, N);
- state IDLE -> PEND.
REQ-018 SHALL define tc = (cnt == N-1).
REQ-019 SHALL, at an edge with tc=1 and state=PEND, perform all of:
- active_duty <= shadow_duty;
- state PEND -> IDLE;
- upd_done <= 1 in the next cycle.
REQ-020 SHALL, at an edge with tc=1 and state=IDLE (a simultaneous accept), capture the new value into shadow only; it applies at the following tc, not the current one.
REQ-021 SHALL ignore duty_valid while in PEND; shadow_duty is unchanged and duty_data need not be held.
REQ-022 SHALL register pwm <= (cnt < active_duty), giving one cycle of latency from cnt to pwm.
REQ-023 SHALL use the new active_duty for the compare starting with cnt=0 of the next period, so there is no glitch period at update.
REQ-024 SHALL produce duty behaviour as follows:
- active_duty = 0: pwm constantly 0;
- active_duty = N: pwm constantly 1;
- otherwise: pwm high for exactly active_duty cycles per N-cycle period.
REQ-025 SHALL register wrap <= tc, so wrap is high the cycle after cnt = N-1.
REQ-026 SHALL treat cnt >= N as illegal, with all of these effects:
- err <= 1 (sticky until reset);
- pwm <= 0 that cycle;
- tc = 0, so no update or wrap occurs.
REQ-027 SHALL clear upd_done and wrap automatically; both are single-cycle pulses.

Reset
REQ-028 SHALL, while rst = 0, immediately force:
- pwm = 0, wrap = 0, upd_done = 0, err = 0;
- active_duty = 0, shadow_duty = 0;
- state = IDLE, hence duty_ready = 1.
REQ-029 SHALL discard any pending shadow value if reset asserts mid-period or in PEND; after release, active_duty = 0 until a new accept is followed by tc.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst deasserts, with no extra idle cycles.

Verification (N=17, cnt driven 0..16 repeating)
REQ-031 SHALL cover reset and idle: release reset, no duty write -> pwm = 0 for 3 full periods, wrap pulses every 17 cycles, duty_ready = 1.
REQ-032 SHALL cover a basic update: accept duty 5 at cnt=3 -> duty_ready = 0 until tc; upd_done pulses once; the next period shows pwm high 5 cycles then low 12, repeating.
REQ-033 SHALL cover the boundary duties 0, 17 and 25:
- duty 17 -> pwm constantly 1;
- duty 0 -> pwm constantly 0;
- duty 25 -> saturated to 17, so pwm constantly 1.
REQ-034 SHALL cover simultaneous events: accept duty 8 on the edge where cnt=16 (IDLE) -> no upd_done at that wrap; the update applies at the following wrap; the period between keeps the old duty.
REQ-035 SHALL cover back-pressure: accept duty 4, then hold duty_valid=1 with duty_data = 9 while in PEND -> 9 is ignored; 4 is applied; 9 is accepted in the cycle after returning to IDLE and is applied at the next wrap.
REQ-036 SHALL cover error and reset mid-operation:
- drive cnt = 20 for one cycle -> err = 1 and stays 1, and pwm = 0 that cycle;
- then assert rst while in PEND -> err, pwm and state clear immediately, and duty_ready = 1.

Source files
------------

// File: rtl/mod_n_pwm.sv
// mod_n_pwm: PWM generator slaved to an upstream mod-N counter.
// A new duty value is taken into a shadow register. It becomes the active
// compare value at the end of the current period, so the waveform never
// shows a partial period.
module mod_n_pwm #(
   parameter int N = 17,
   localparam int CW = $clog2(N),
   localparam int DW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] cnt,
   input  logic [DW-1:0] duty_data,
   input  logic          duty_valid,
   output logic          duty_ready,
   output logic          pwm,
   output logic          wrap,
   output logic          upd_done,
   output logic          err
);

   // Handshake: a duty value transfers on a rising clk edge when
   // duty_valid && duty_ready are both high. duty_ready depends only on state.
   // While duty_ready is low, duty_valid is ignored and duty_data need not be held.

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PEND = 1'b1;

   localparam logic [CW:0]   N_EXT  = (CW + 1)'(N);
   localparam logic [CW-1:0] LAST   = CW'(N - 1);
   localparam logic [DW-1:0] N_DUTY = DW'(N);

   logic [0:0]    state;
   logic [DW-1:0] active_duty;
   logic [DW-1:0] shadow_duty;

   logic          cnt_legal;
   logic          tc;
   logic          accept;
   logic [DW-1:0] duty_sat;
   logic [DW-1:0] cnt_ext;

   // Decode counter legality, terminal count, accept and the saturated duty.
   always_comb begin
      cnt_legal = ({1'b0, cnt} < N_EXT);
      tc        = cnt_legal && (cnt == LAST);
      accept    = duty_valid && duty_ready;
      duty_sat  = (duty_data > N_DUTY) ? N_DUTY : duty_data;
      cnt_ext   = DW'(cnt);
   end

   assign duty_ready = (state == IDLE);

   // Handshake FSM: IDLE accepts into the shadow register; PEND applies the shadow at tc.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         shadow_duty <= '0;
         active_duty <= '0;
         upd_done    <= 1'b0;
      end else begin
         upd_done <= 1'b0;
         case (state)
            IDLE: begin
               // An accept on the tc edge only fills the shadow register.
               // The new value applies at the next tc.
               if (accept) begin
                  shadow_duty <= duty_sat;
                  state       <= PEND;
               end
            end
            PEND: begin
               if (tc) begin
                  active_duty <= shadow_duty;
                  state       <= IDLE;
                  upd_done    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output waveform, period-end pulse and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm  <= 1'b0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         // active_duty changes on the tc edge, so cnt=0 of the next period
         // is the first count compared against the new duty.
         pwm  <= cnt_legal && (cnt_ext < active_duty);
         wrap <= tc;
         if (!cnt_legal) begin
            err <= 1'b1;
         end
      end
   end

endmodule
